mem_arb_ctrl: RTL and testbench
===============================

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per word (one bit_slice column per bit).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports a_req / b_req  in  1  access request from requester A / B.
REQ-005 SHALL have ports a_we / b_we  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports a_addr / b_addr  in  2  word address 0..3.
REQ-007 SHALL have ports a_wdata / b_wdata  in  WIDTH  write data.
REQ-008 SHALL have ports a_ack / b_ack  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports a_rdata / b_rdata  out  WIDTH  read result, registered.
REQ-010 SHALL have port ram_word_sel  out  4  one-hot word select to the array.
REQ-011 SHALL have port ram_rw  out  1  array rw_mode, 1 = write.
REQ-012 SHALL have port ram_wdata  out  WIDTH (+1 with parity)  array data input.
REQ-013 SHALL have port ram_rdata  in  WIDTH (+1 with parity)  array read output.
REQ-014 SHALL have port err  out  1  parity-error pulse (REQ-027).

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE, one cycle per state except IDLE.
REQ-016 IDLE: on any sampled req, SHALL grant one requester and capture its we/addr/wdata into internal registers; no req -> stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single req granted directly; both asserted -> the requester not granted last; after reset A has priority.
REQ-018 SETUP: ram_word_sel SHALL be the one-hot decode of the captured address, ram_wdata SHALL be the captured data, ram_rw 0.
REQ-019 ACCESS: word_sel, wdata held; ram_rw SHALL be 1 for writes, 0 for reads; reads SHALL capture ram_rdata into the granted port's rdata at the end of ACCESS.
REQ-020 DONE: SHALL pulse the granted port's ack for exactly one cycle; ram_word_sel = 0, ram_rw = 0.
REQ-021 Latency SHALL be fixed: req sampled at edge N -> ack high during cycle N+3; back-to-back per port = 4 cycles.
REQ-022 Requester SHALL hold req until ack; a req still high in the cycle after ack is treated as a new request.
REQ-023 ram_word_sel SHALL be 0 and ram_rw SHALL be 0 in IDLE and DONE; never more than one word_sel bit set.
REQ-024 a_rdata/b_rdata SHALL hold their last value until the next read completes on that port; writes do not alter them.
REQ-025 Changes to an ungranted port's inputs during a transaction SHALL have no effect until the next IDLE.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, acks 0, rdata 0, ram_word_sel 0, ram_rw 0, ram_wdata 0, err 0, RR pointer to "A first"; an in-flight transaction is dropped without ack.

Configuration
REQ-027 With MEM_ARB_CTRL_PARITY_EN defined: ram_wdata/ram_rdata are WIDTH+1, bit WIDTH = even parity (XOR of data); on a read, mismatch SHALL pulse err together with ack; rdata still returns data bits.
REQ-028 Without MEM_ARB_CTRL_PARITY_EN: buses are WIDTH bits, err tied 0, no parity logic.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the FSM state enum, ADDR_W = 2, DEPTH = 4 and the grant-id type (GNT_A, GNT_B).
REQ-030 Arbitration SHALL be a sub-module rr_arbiter2 (two reqs, pointer register, one-hot grant); decode/FSM stay in mem_arb_ctrl.

Verification
REQ-031 Reset mid-ACCESS of an A write -> next cycle ram_word_sel=0, ram_rw=0, no a_ack.
REQ-032 A write addr 2 data 0x5A, then A read addr 2 -> ram_word_sel=4'b0100, ram_rw=1 only in ACCESS; a_rdata=0x5A at ack, ack 3 cycles after req sample.
REQ-033 A and B assert same edge after reset -> A acked first, B acked 4 cycles later; repeated tie -> B first.
REQ-034 B write addr 3 data 0xFF while A req held -> A starts only after B's DONE; a_rdata unchanged.
REQ-035 Parity build: force bad parity on ram_rdata during a read of addr 1 -> err and ack high same cycle; non-parity build: err stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter/controller slice:
//   - ADDR_W / DEPTH : word address width and number of words in the array
//   - arb_state_t    : controller FSM states (IDLE, SETUP, ACCESS, DONE)
//   - gnt_id_t       : which requester currently owns the array (A or B)
//   - addr_onehot()  : word address to one-hot word-select decode
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_id_t;

    // Decodes a word address into the one-hot select the array expects.
    function automatic logic [DEPTH-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [DEPTH-1:0] sel;
        sel       = '0;
        sel[addr] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter with a single pointer register.
// A lone request is granted directly; when both requests are present the
// requester that was not granted last wins. After reset A wins a tie.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset (pointer back to "A first")
//   req    in  2  request vector, bit 0 = A, bit 1 = B
//   accept in  1  the current grant is being taken; advance the pointer
//   grant  out 2  one-hot grant, bit 0 = A, bit 1 = B (zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic b_first;

    // Grant decode: only a tie consults the pointer, a single request always
    // wins outright so an idle partner never delays it.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = b_first ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer update: whoever is accepted now goes to the back of the line,
    // so granting A hands the next tie to B and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_first <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            b_first <= grant[0];
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// ---------------------------------------------------------------------------
// mem_arb_ctrl
// Arbitrates two requesters (A, B) onto a single 4-word memory array and
// sequences each access as IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
// A request sampled in IDLE at edge N is acknowledged during cycle N+3;
// a port can be served again every 4 cycles.
//
// Optional feature: define MEM_ARB_CTRL_PARITY_EN to widen the array buses by
// one even-parity bit (bit WIDTH) and pulse err with ack on a read mismatch.
// Without it the buses are WIDTH bits and err is tied low.
//
// Ports:
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous active-low reset
//   a_req/b_req   in   1        access request, held until ack
//   a_we/b_we     in   1        1 = write, 0 = read
//   a_addr/b_addr in   2        word address
//   a_wdata/b_wdata in WIDTH    write data
//   a_ack/b_ack   out  1        one-cycle completion pulse
//   a_rdata/b_rdata out WIDTH   registered read result
//   ram_word_sel  out  4        one-hot word select to the array
//   ram_rw        out  1        array rw_mode, 1 = write
//   ram_wdata     out  WIDTH(+1) array data input
//   ram_rdata     in   WIDTH(+1) array read output
//   err           out  1        parity-error pulse
// ---------------------------------------------------------------------------
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    input  logic [WIDTH-1:0]  b_wdata,
    output logic              a_ack,
    output logic              b_ack,
    output logic [WIDTH-1:0]  a_rdata,
    output logic [WIDTH-1:0]  b_rdata,
    output logic [DEPTH-1:0]  ram_word_sel,
    output logic              ram_rw,
`ifdef MEM_ARB_CTRL_PARITY_EN
    output logic [WIDTH:0]    ram_wdata,
    input  logic [WIDTH:0]    ram_rdata,
`else
    output logic [WIDTH-1:0]  ram_wdata,
    input  logic [WIDTH-1:0]  ram_rdata,
`endif
    output logic              err
);

    arb_state_t        state;
    arb_state_t        next_state;
    gnt_id_t           gnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [WIDTH-1:0]  cap_wdata;
    logic [1:0]        arb_grant;
    logic              arb_accept;
    logic              capture_read;

`ifdef MEM_ARB_CTRL_PARITY_EN
    logic [WIDTH:0]    bus_word;
    assign bus_word = {^cap_wdata, cap_wdata};
`else
    logic [WIDTH-1:0]  bus_word;
    assign bus_word = cap_wdata;
`endif

    // The arbiter only looks at raw requests; it is told to advance its
    // pointer exactly when the FSM takes a grant in IDLE, so requests seen in
    // the middle of a transaction never move the round-robin order.
    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({b_req, a_req}),
        .accept (arb_accept),
        .grant  (arb_grant)
    );

    // State register. Reset drops any in-flight transaction straight back to
    // IDLE, which also kills the pending ack since ack is decoded from DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and array-side outputs. The word select and data are driven
    // in SETUP so the array sees a stable address before rw goes high in
    // ACCESS; IDLE and DONE keep the array completely quiet.
    always_comb begin
        next_state   = state;
        arb_accept   = 1'b0;
        capture_read = 1'b0;
        ram_word_sel = '0;
        ram_rw       = 1'b0;
        ram_wdata    = '0;
        a_ack        = 1'b0;
        b_ack        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_grant != 2'b00) begin
                    arb_accept = 1'b1;
                    next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ram_word_sel = addr_onehot(cap_addr);
                ram_wdata    = bus_word;
                next_state   = ST_ACCESS;
            end
            ST_ACCESS: begin
                ram_word_sel = addr_onehot(cap_addr);
                ram_wdata    = bus_word;
                ram_rw       = cap_we;
                capture_read = !cap_we;
                next_state   = ST_DONE;
            end
            ST_DONE: begin
                a_ack      = (gnt == GNT_A);
                b_ack      = (gnt == GNT_B);
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture. The winner's command is frozen at the grant so the
    // requester (or the losing port) can change its inputs afterwards without
    // disturbing the access already under way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= GNT_A;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (arb_accept) begin
            if (arb_grant[1]) begin
                gnt       <= GNT_B;
                cap_we    <= b_we;
                cap_addr  <= b_addr;
                cap_wdata <= b_wdata;
            end else begin
                gnt       <= GNT_A;
                cap_we    <= a_we;
                cap_addr  <= a_addr;
                cap_wdata <= a_wdata;
            end
        end
    end

    // Read-data return. Array output is sampled at the end of ACCESS into the
    // owning port only; the other port and all writes leave rdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (capture_read) begin
            if (gnt == GNT_A) begin
                a_rdata <= ram_rdata[WIDTH-1:0];
            end else begin
                b_rdata <= ram_rdata[WIDTH-1:0];
            end
        end
    end

`ifdef MEM_ARB_CTRL_PARITY_EN
    // Parity check. With even parity the XOR over data plus parity bit is zero
    // for a good word, so a nonzero reduction flags the read. The flag is
    // registered on the same edge as rdata so it lines up with the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= capture_read && (^ram_rdata);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_arb_ctrl
// Testbench for mem_arb_ctrl. A behavioural 4-word array sits on the ram_*
// buses; expected values come from transaction-level bookkeeping (memory
// contents, round-robin order, fixed 4-cycle access timing).
// Build with MEM_ARB_CTRL_PARITY_EN defined to exercise the parity variant.
// ---------------------------------------------------------------------------
module tb_mem_arb_ctrl;

    localparam int W = 8;
`ifdef MEM_ARB_CTRL_PARITY_EN
    localparam int BUS_W     = W + 1;
    localparam bit PARITY_ON = 1'b1;
`else
    localparam int BUS_W     = W;
    localparam bit PARITY_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             a_req, b_req, a_we, b_we;
    logic [1:0]       a_addr, b_addr;
    logic [W-1:0]     a_wdata, b_wdata;
    logic             a_ack, b_ack;
    logic [W-1:0]     a_rdata, b_rdata;
    logic [3:0]       ram_word_sel;
    logic             ram_rw;
    logic [BUS_W-1:0] ram_wdata;
    logic [BUS_W-1:0] ram_rdata;
    logic             err;

    logic [BUS_W-1:0] bench_ram [4] = '{default: '0};
    logic [BUS_W-1:0] rd_flip;

    logic [W-1:0]     model_mem [4];
    logic [W-1:0]     exp_a_rdata;
    logic [W-1:0]     exp_b_rdata;
    int               checks;
    int               errors;

    mem_arb_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req        (a_req),
        .b_req        (b_req),
        .a_we         (a_we),
        .b_we         (b_we),
        .a_addr       (a_addr),
        .b_addr       (b_addr),
        .a_wdata      (a_wdata),
        .b_wdata      (b_wdata),
        .a_ack        (a_ack),
        .b_ack        (b_ack),
        .a_rdata      (a_rdata),
        .b_rdata      (b_rdata),
        .ram_word_sel (ram_word_sel),
        .ram_rw       (ram_rw),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: combinational read of the selected word (with an
    // optional bit flip to inject errors), write on the clock when rw is high.
    always_comb begin
        ram_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (ram_word_sel[i]) ram_rdata = bench_ram[i] ^ rd_flip;
        end
    end

    always @(posedge clk) begin
        if (ram_rw) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_word_sel[i]) bench_ram[i] <= ram_wdata;
            end
        end
    end

    function automatic logic [BUS_W-1:0] exp_bus(input logic [W-1:0] d);
`ifdef MEM_ARB_CTRL_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [1:0] addr, input logic [W-1:0] data);
        if (port == 0) begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = data;
        end else begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = data;
        end
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
    endtask

    task automatic test_reset();
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
        rst_n = 1'b0;
        step();
        step();
        checks += 8;
        if (a_ack !== 1'b0)        begin errors++; $display("[TB] FAIL reset_a_ack: got %b expected 0", a_ack); end
        if (b_ack !== 1'b0)        begin errors++; $display("[TB] FAIL reset_b_ack: got %b expected 0", b_ack); end
        if (a_rdata !== 8'h00)     begin errors++; $display("[TB] FAIL reset_a_rdata: got %h expected 00", a_rdata); end
        if (b_rdata !== 8'h00)     begin errors++; $display("[TB] FAIL reset_b_rdata: got %h expected 00", b_rdata); end
        if (ram_word_sel !== 4'h0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0000", ram_word_sel); end
        if (ram_rw !== 1'b0)       begin errors++; $display("[TB] FAIL reset_rw: got %b expected 0", ram_rw); end
        if (ram_wdata !== '0)      begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", ram_wdata); end
        if (err !== 1'b0)          begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        #3 rst_n = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        step();
    endtask

    task automatic test_write_read();
        logic [3:0] exp_sel;
        applyStimulus(0, 1'b1, 1'b1, 2'd2, 8'h5A);
        step();
        for (int k = 0; k < 4; k++) begin
            exp_sel = (k < 2) ? 4'b0100 : 4'b0000;
            checks += 3;
            if (ram_word_sel !== exp_sel) begin errors++; $display("[TB] FAIL wr_sel k=%0d: got %b expected %b", k, ram_word_sel, exp_sel); end
            if (ram_rw !== (k == 1))      begin errors++; $display("[TB] FAIL wr_rw k=%0d: got %b expected %b", k, ram_rw, (k == 1)); end
            if (a_ack !== (k == 2))       begin errors++; $display("[TB] FAIL wr_ack k=%0d: got %b expected %b", k, a_ack, (k == 2)); end
            if (k < 2) begin
                checks++;
                if (ram_wdata !== exp_bus(8'h5A)) begin errors++; $display("[TB] FAIL wr_wdata k=%0d: got %h expected %h", k, ram_wdata, exp_bus(8'h5A)); end
            end
            if (k == 2) applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
            if (k < 3) step();
        end
        model_mem[2] = 8'h5A;

        applyStimulus(0, 1'b1, 1'b0, 2'd2, 8'($urandom));
        step();
        for (int k = 0; k < 4; k++) begin
            exp_sel = (k < 2) ? 4'b0100 : 4'b0000;
            checks += 5;
            if (ram_word_sel !== exp_sel) begin errors++; $display("[TB] FAIL rd_sel k=%0d: got %b expected %b", k, ram_word_sel, exp_sel); end
            if (ram_rw !== 1'b0)          begin errors++; $display("[TB] FAIL rd_rw k=%0d: got %b expected 0", k, ram_rw); end
            if (a_ack !== (k == 2))       begin errors++; $display("[TB] FAIL rd_ack k=%0d: got %b expected %b", k, a_ack, (k == 2)); end
            if (a_rdata !== ((k >= 2) ? 8'h5A : exp_a_rdata)) begin errors++; $display("[TB] FAIL rd_a_rdata k=%0d: got %h expected %h", k, a_rdata, (k >= 2) ? 8'h5A : exp_a_rdata); end
            if (b_rdata !== exp_b_rdata)  begin errors++; $display("[TB] FAIL rd_b_rdata k=%0d: got %h expected %h", k, b_rdata, exp_b_rdata); end
            if (k == 2) applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
            if (k < 3) step();
        end
        exp_a_rdata = 8'h5A;
    endtask

    task automatic test_reset_mid_access();
        applyStimulus(0, 1'b1, 1'b1, 2'd1, 8'h33);
        step();
        step();
        checks += 2;
        if (ram_word_sel !== 4'b0010) begin errors++; $display("[TB] FAIL mid_pre_sel: got %b expected 0010", ram_word_sel); end
        if (ram_rw !== 1'b1)          begin errors++; $display("[TB] FAIL mid_pre_rw: got %b expected 1", ram_rw); end
        #2 rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        #1;
        checks += 4;
        if (ram_word_sel !== 4'h0) begin errors++; $display("[TB] FAIL mid_sel: got %b expected 0000", ram_word_sel); end
        if (ram_rw !== 1'b0)       begin errors++; $display("[TB] FAIL mid_rw: got %b expected 0", ram_rw); end
        if (a_ack !== 1'b0)        begin errors++; $display("[TB] FAIL mid_ack: got %b expected 0", a_ack); end
        if (a_rdata !== 8'h00)     begin errors++; $display("[TB] FAIL mid_a_rdata: got %h expected 00", a_rdata); end
        #4 rst_n = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks += 2;
            if (a_ack !== 1'b0)        begin errors++; $display("[TB] FAIL mid_post_ack k=%0d: got %b expected 0", k, a_ack); end
            if (ram_word_sel !== 4'h0) begin errors++; $display("[TB] FAIL mid_post_sel k=%0d: got %b expected 0000", k, ram_word_sel); end
        end
    endtask

    task automatic test_tie();
        int         t_port [3] = '{0, 1, 0};
        logic       t_we   [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] t_addr [3] = '{2'd0, 2'd1, 2'd1};
        logic [W-1:0] d0, db;
        logic [3:0] exp_sel;
        logic       exp_rw, exp_aa, exp_ba;
        int         i, ph;
        pulse_reset();
        d0 = 8'($urandom);
        db = 8'($urandom);
        applyStimulus(0, 1'b1, 1'b1, 2'd0, d0);
        applyStimulus(1, 1'b1, 1'b1, 2'd1, db);
        step();
        for (int k = 0; k < 12; k++) begin
            i  = k / 4;
            ph = k % 4;
            exp_sel = (i < 3 && ph < 2) ? (4'b0001 << t_addr[i]) : 4'b0000;
            exp_rw  = (i < 3 && ph == 1) ? t_we[i] : 1'b0;
            exp_aa  = (i < 3 && ph == 2 && t_port[i] == 0);
            exp_ba  = (i < 3 && ph == 2 && t_port[i] == 1);
            checks += 4;
            if (ram_word_sel !== exp_sel) begin errors++; $display("[TB] FAIL tie_sel k=%0d: got %b expected %b", k, ram_word_sel, exp_sel); end
            if (ram_rw !== exp_rw)        begin errors++; $display("[TB] FAIL tie_rw k=%0d: got %b expected %b", k, ram_rw, exp_rw); end
            if (a_ack !== exp_aa)         begin errors++; $display("[TB] FAIL tie_a_ack k=%0d: got %b expected %b", k, a_ack, exp_aa); end
            if (b_ack !== exp_ba)         begin errors++; $display("[TB] FAIL tie_b_ack k=%0d: got %b expected %b", k, b_ack, exp_ba); end
            if (k == 2)  applyStimulus(0, 1'b1, 1'b0, 2'd1, 8'($urandom));
            if (k == 6)  applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
            if (k == 10) begin
                checks++;
                if (a_rdata !== db) begin errors++; $display("[TB] FAIL tie_a_rdata: got %h expected %h", a_rdata, db); end
                applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
            end
            if (k < 11) step();
        end
        model_mem[0] = d0;
        model_mem[1] = db;
        exp_a_rdata  = db;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] prev_a;
        logic [3:0]   exp_sel;
        prev_a = exp_a_rdata;
        applyStimulus(1, 1'b1, 1'b1, 2'd3, 8'hFF);
        step();
        for (int k = 0; k < 8; k++) begin
            exp_sel = (k < 2 || k == 4 || k == 5) ? 4'b1000 : 4'b0000;
            checks += 6;
            if (ram_word_sel !== exp_sel) begin errors++; $display("[TB] FAIL b2b_sel k=%0d: got %b expected %b", k, ram_word_sel, exp_sel); end
            if (ram_rw !== (k == 1))      begin errors++; $display("[TB] FAIL b2b_rw k=%0d: got %b expected %b", k, ram_rw, (k == 1)); end
            if (b_ack !== (k == 2))       begin errors++; $display("[TB] FAIL b2b_b_ack k=%0d: got %b expected %b", k, b_ack, (k == 2)); end
            if (a_ack !== (k == 6))       begin errors++; $display("[TB] FAIL b2b_a_ack k=%0d: got %b expected %b", k, a_ack, (k == 6)); end
            if (a_rdata !== ((k >= 6) ? 8'hFF : prev_a)) begin errors++; $display("[TB] FAIL b2b_a_rdata k=%0d: got %h expected %h", k, a_rdata, (k >= 6) ? 8'hFF : prev_a); end
            if (b_rdata !== exp_b_rdata)  begin errors++; $display("[TB] FAIL b2b_b_rdata k=%0d: got %h expected %h", k, b_rdata, exp_b_rdata); end
            if (k < 3)  applyStimulus(0, 1'b1, 1'($urandom), 2'($urandom), 8'($urandom));
            if (k == 3) applyStimulus(0, 1'b1, 1'b0, 2'd3, 8'($urandom));
            if (k == 2) applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
            if (k == 6) applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
            if (k < 7) step();
        end
        model_mem[3] = 8'hFF;
        exp_a_rdata  = 8'hFF;
    endtask

    task automatic test_parity();
        logic [W-1:0] d;
        logic         exp_err;
        d = 8'($urandom);
        applyStimulus(0, 1'b1, 1'b1, 2'd1, d);
        step();
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (a_ack !== (k == 2)) begin errors++; $display("[TB] FAIL par_wr_ack k=%0d: got %b expected %b", k, a_ack, (k == 2)); end
            if (err !== 1'b0)       begin errors++; $display("[TB] FAIL par_wr_err k=%0d: got %b expected 0", k, err); end
            if (k == 2) applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
            if (k < 3) step();
        end
        model_mem[1] = d;
`ifdef MEM_ARB_CTRL_PARITY_EN
        rd_flip = {1'b1, {W{1'b0}}};
`else
        rd_flip = '0;
`endif
        applyStimulus(1, 1'b1, 1'b0, 2'd1, 8'($urandom));
        step();
        for (int k = 0; k < 4; k++) begin
            exp_err = (k == 2) && PARITY_ON;
            checks += 3;
            if (b_ack !== (k == 2)) begin errors++; $display("[TB] FAIL par_rd_ack k=%0d: got %b expected %b", k, b_ack, (k == 2)); end
            if (err !== exp_err)    begin errors++; $display("[TB] FAIL par_rd_err k=%0d: got %b expected %b", k, err, exp_err); end
            if (b_rdata !== ((k >= 2) ? d : exp_b_rdata)) begin errors++; $display("[TB] FAIL par_rd_data k=%0d: got %h expected %h", k, b_rdata, (k >= 2) ? d : exp_b_rdata); end
            if (k == 2) applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
            if (k < 3) step();
        end
        rd_flip     = '0;
        exp_b_rdata = d;
    endtask

    task automatic test_random();
        bit           pend   [2];
        logic         p_we   [2];
        logic [1:0]   p_addr [2];
        logic [W-1:0] p_data [2];
        int           t, free_edge, cur_start, cur_port, k;
        bit           b_first;
        logic         cur_we;
        logic [1:0]   cur_addr;
        logic [W-1:0] cur_data;
        logic [3:0]   exp_sel;
        logic         exp_rw, exp_aa, exp_ba;
        pulse_reset();
        b_first   = 1'b0;
        free_edge = 0;
        cur_start = -100;
        cur_port  = 0;
        cur_we    = 1'b0;
        cur_addr  = 2'd0;
        cur_data  = '0;
        t         = 0;
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]   = 1'b1;
                    p_we[p]   = 1'($urandom);
                    p_addr[p] = 2'($urandom);
                    p_data[p] = 8'($urandom);
                end
                if (pend[p]) applyStimulus(p, 1'b1, p_we[p], p_addr[p], p_data[p]);
                else         applyStimulus(p, 1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
            end
            step();
            t++;
            if (t >= free_edge && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) cur_port = b_first ? 1 : 0;
                else                    cur_port = pend[1] ? 1 : 0;
                b_first   = (cur_port == 0);
                cur_start = t;
                free_edge = t + 4;
                cur_we    = p_we[cur_port];
                cur_addr  = p_addr[cur_port];
                cur_data  = p_data[cur_port];
            end
            k       = t - cur_start;
            exp_sel = (k == 0 || k == 1) ? (4'b0001 << cur_addr) : 4'b0000;
            exp_rw  = (k == 1) && cur_we;
            exp_aa  = (k == 2) && (cur_port == 0);
            exp_ba  = (k == 2) && (cur_port == 1);
            if (k == 2) begin
                if (cur_we)             model_mem[cur_addr] = cur_data;
                else if (cur_port == 0) exp_a_rdata = model_mem[cur_addr];
                else                    exp_b_rdata = model_mem[cur_addr];
                pend[cur_port] = 1'b0;
            end
            checks += 7;
            if (ram_word_sel !== exp_sel) begin errors++; $display("[TB] FAIL rnd_sel t=%0d: got %b expected %b", t, ram_word_sel, exp_sel); end
            if (ram_rw !== exp_rw)        begin errors++; $display("[TB] FAIL rnd_rw t=%0d: got %b expected %b", t, ram_rw, exp_rw); end
            if (a_ack !== exp_aa)         begin errors++; $display("[TB] FAIL rnd_a_ack t=%0d: got %b expected %b", t, a_ack, exp_aa); end
            if (b_ack !== exp_ba)         begin errors++; $display("[TB] FAIL rnd_b_ack t=%0d: got %b expected %b", t, b_ack, exp_ba); end
            if (a_rdata !== exp_a_rdata)  begin errors++; $display("[TB] FAIL rnd_a_rdata t=%0d: got %h expected %h", t, a_rdata, exp_a_rdata); end
            if (b_rdata !== exp_b_rdata)  begin errors++; $display("[TB] FAIL rnd_b_rdata t=%0d: got %h expected %h", t, b_rdata, exp_b_rdata); end
            if (err !== 1'b0)             begin errors++; $display("[TB] FAIL rnd_err t=%0d: got %b expected 0", t, err); end
            if (k == 0 || k == 1) begin
                checks++;
                if (ram_wdata !== exp_bus(cur_data)) begin errors++; $display("[TB] FAIL rnd_wdata t=%0d: got %h expected %h", t, ram_wdata, exp_bus(cur_data)); end
            end
        end
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (6) step();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rd_flip     = '0;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        for (int i = 0; i < 4; i++) model_mem[i] = '0;
        rst_n = 1'b0;
        $display("[TB] starting mem_arb_ctrl bench (parity=%0d)", PARITY_ON);
        test_reset();
        test_write_read();
        test_reset_mid_access();
        test_tie();
        test_back_to_back();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
